// File: rtl/xoodyak_op_seq.sv
// xoodyak_op_seq
//   Command sequencer in front of the Xoodyak core. Commands (opmode + payload)
//   are buffered in a small FIFO and issued to the core one at a time. Each
//   issue is a single-cycle start pulse. Text results of crypt/decrypt/squeeze
//   operations come back through a valid/ready response port.
//
// Parameters
//   DEPTH   : command FIFO entries (power of two, >= 2)
//   TEXT_W  : width of command payload and core text in/out
//   TIMEOUT : WAIT cycles allowed before the sticky error (timeout build only)
//
// Ports
//   eph1, reset                  : clock and synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command push port
//   fifo_count                   : occupied FIFO entries
//   core_start/core_opmode/core_textin  : issue port to the core
//   core_finished/core_textout   : completion port from the core
//   rsp_valid/rsp_ready/rsp_op/rsp_data : result port
//   busy                         : sequencer active or commands pending
//   err                          : sticky timeout error
//
// Build option
//   XOODYAK_SEQ_TIMEOUT_EN : when defined, a WAIT that lasts TIMEOUT cycles
//   without core_finished moves to the ERR state, which only reset leaves.
//   When undefined, WAIT waits indefinitely and err is tied low.

module xoodyak_op_seq #(
  parameter int DEPTH   = 4,
  parameter int TEXT_W  = 192,
  parameter int TIMEOUT = 255
) (
  input  logic                    eph1,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [TEXT_W-1:0]       cmd_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    core_start,
  output logic [3:0]              core_opmode,
  output logic [TEXT_W-1:0]       core_textin,
  input  logic                    core_finished,
  input  logic [TEXT_W-1:0]       core_textout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_op,
  output logic [TEXT_W-1:0]       rsp_data,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  // Command storage, written on push, read combinationally at the head.
  logic [3:0]        op_mem   [DEPTH];
  logic [TEXT_W-1:0] data_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  logic [3:0]        opmode_q, opmode_d;
  logic [TEXT_W-1:0] textin_q, textin_d;
  logic [3:0]        rsp_op_q, rsp_op_d;
  logic [TEXT_W-1:0] rsp_data_q, rsp_data_d;

  logic [3:0]        head_op;
  logic [TEXT_W-1:0] head_data;

  assign head_op   = op_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // Ready is gated by the reset input so nothing is accepted while reset is held.
  assign cmd_ready = reset && (count_q != CW'(DEPTH)) && (state_q != S_ERR);
  assign push      = cmd_valid && cmd_ready;

`ifdef XOODYAK_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Holds zero outside WAIT, so it restarts on every entry into WAIT.
  // During WAIT cycle k the counter holds k-1.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign err = (state_q == S_ERR);
`else
  // TIMEOUT has no effect in this build.
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT > 0);
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    opmode_d   = opmode_q;
    textin_d   = textin_q;
    rsp_op_d   = rsp_op_q;
    rsp_data_d = rsp_data_q;
    pop        = 1'b0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          // Idle opcodes are discarded without touching the core.
          if (head_op[2:0] != 3'd0) begin
            opmode_d = head_op;
            textin_d = head_data;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A completion that coincides with the timeout limit still counts.
        if (core_finished) begin
          if (opmode_q[2:0] inside {3'd4, 3'd5, 3'd6}) begin
            rsp_op_d   = opmode_q;
            rsp_data_d = core_textout;
            state_d    = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef XOODYAK_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
`endif
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge eph1) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= cmd_op;
      data_mem[wr_ptr_q] <= cmd_data;
    end
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      opmode_q   <= '0;
      textin_q   <= '0;
      rsp_op_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      opmode_q   <= opmode_d;
      textin_q   <= textin_d;
      rsp_op_q   <= rsp_op_d;
      rsp_data_q <= rsp_data_d;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign fifo_count  = count_q;
  assign core_opmode = opmode_q;
  assign core_textin = textin_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_xoodyak_op_seq.sv
// Testbench for xoodyak_op_seq: directed table of single commands, hand-written
// multi-cycle sequences (FIFO full, reset during WAIT, timeout), and a random
// command stream scored against a queue-based model of the command stream.

module tb_xoodyak_op_seq;

  localparam int DEPTH  = 4;
  localparam int TEXT_W = 192;
  localparam int TMO    = 16;

  logic              eph1 = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op = 4'h0;
  logic [TEXT_W-1:0] cmd_data = '0;
  logic [2:0]        fifo_count;
  logic              core_start;
  logic [3:0]        core_opmode;
  logic [TEXT_W-1:0] core_textin;
  logic              core_finished = 1'b0;
  logic [TEXT_W-1:0] core_textout = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [3:0]        rsp_op;
  logic [TEXT_W-1:0] rsp_data;
  logic              busy;
  logic              err;

  xoodyak_op_seq #(.DEPTH(DEPTH), .TEXT_W(TEXT_W), .TIMEOUT(TMO)) dut (
    .eph1(eph1), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .fifo_count(fifo_count),
    .core_start(core_start), .core_opmode(core_opmode), .core_textin(core_textin),
    .core_finished(core_finished), .core_textout(core_textout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  always #5 eph1 = ~eph1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Result function of the core model (rotate left by one byte, invert).
  function automatic logic [TEXT_W-1:0] xf(input logic [TEXT_W-1:0] d);
    return ~{d[TEXT_W-9:0], d[TEXT_W-1 -: 8]};
  endfunction

  // ---------------- core model ----------------
  bit                core_stall = 1'b0;
  bit                use_fixed  = 1'b0;
  bit                rand_lat   = 1'b0;
  int                core_lat   = 1;
  logic [TEXT_W-1:0] fixed_out  = '0;
  bit                c_busy     = 1'b0;
  int                c_cnt      = 0;
  logic [TEXT_W-1:0] c_pend     = '0;

  always @(negedge eph1) begin
    core_finished = 1'b0;
    if (core_start) begin
      c_busy = 1'b1;
      c_cnt  = rand_lat ? int'($urandom_range(1, 6)) : core_lat;
      c_pend = use_fixed ? fixed_out : xf(core_textin);
    end else if (c_busy && !core_stall) begin
      if (c_cnt <= 1) begin
        core_finished = 1'b1;
        core_textout  = c_pend;
        c_busy        = 1'b0;
      end else begin
        c_cnt--;
      end
    end
  end

  // ---------------- reference model (command stream) ----------------
  typedef struct {
    logic [3:0]        op;
    logic [TEXT_W-1:0] data;
  } item_t;

  item_t exp_iss[$];
  item_t exp_rsp[$];
  bit    sb_en = 1'b0;

  logic              s_acc, s_start, s_rsp_valid, s_busy, s_err, s_ready;
  logic [2:0]        s_count;
  logic [3:0]        s_opmode, s_rsp_op;
  logic [TEXT_W-1:0] s_textin, s_rsp_data;

  // One clock cycle: sample just before the rising edge, then move to the
  // following falling edge where the next inputs are driven.
  task automatic cyc();
    item_t it;
    #4;
    s_ready     = cmd_ready;
    s_acc       = cmd_valid && cmd_ready;
    s_start     = core_start;
    s_opmode    = core_opmode;
    s_textin    = core_textin;
    s_rsp_valid = rsp_valid;
    s_rsp_op    = rsp_op;
    s_rsp_data  = rsp_data;
    s_busy      = busy;
    s_err       = err;
    s_count     = fifo_count;
    if (sb_en) begin
      chk("ready_rule", 256'(s_ready), 256'(reset && (s_count != 3'(DEPTH)) && !s_err));
      if (s_start) begin
        if (exp_iss.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_start: got core_start op %h, required no start", s_opmode);
        end else begin
          it = exp_iss.pop_front();
          chk("sb_opmode", 256'(s_opmode), 256'(it.op));
          chk("sb_textin", 256'(s_textin), 256'(it.data));
        end
      end
      if (s_rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_rsp: got response op %h, required none", s_rsp_op);
        end else begin
          it = exp_rsp.pop_front();
          chk("sb_rsp_op", 256'(s_rsp_op), 256'(it.op));
          chk("sb_rsp_data", 256'(s_rsp_data), 256'(it.data));
        end
      end
      if (s_acc && cmd_op[2:0] != 3'd0) begin
        exp_iss.push_back('{op: cmd_op, data: cmd_data});
        if (cmd_op[2:0] inside {3'd4, 3'd5, 3'd6}) begin
          exp_rsp.push_back('{op: cmd_op, data: xf(cmd_data)});
        end
      end
      if (!reset) begin
        exp_iss.delete();
        exp_rsp.delete();
      end
    end
    @(negedge eph1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},   256'(cmd_ready),   256'(0));
    chk({tag, "_core_start"},  256'(core_start),  256'(0));
    chk({tag, "_core_opmode"}, 256'(core_opmode), 256'(0));
    chk({tag, "_core_textin"}, 256'(core_textin), 256'(0));
    chk({tag, "_rsp_valid"},   256'(rsp_valid),   256'(0));
    chk({tag, "_rsp_op"},      256'(rsp_op),      256'(0));
    chk({tag, "_rsp_data"},    256'(rsp_data),    256'(0));
    chk({tag, "_fifo_count"},  256'(fifo_count),  256'(0));
    chk({tag, "_busy"},        256'(busy),        256'(0));
    chk({tag, "_err"},         256'(err),         256'(0));
  endtask

  task automatic drain(input string tag, input int bound);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (!busy) break;
      cyc();
    end
    chk({tag, "_drained"}, 256'(busy), 256'(0));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]        op;
    logic [TEXT_W-1:0] data;
    int                lat;
    bit                exp_start;
    bit                exp_rsp;
    logic [TEXT_W-1:0] textout;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int                nstart, start_k, rsp_k, nacc, nrsp;
  bit                stable, busy_at, err18;
  logic [3:0]        st_op, r_op;
  logic [TEXT_W-1:0] st_txt, r_data;

  initial begin
    vecs[0] = '{op: 4'h1, data: {6{32'h01234567}}, lat: 5, exp_start: 1'b1, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[1] = '{op: 4'h4, data: 192'h4d4e4f5051525354555657584142434445464748494a4b4c, lat: 3,
                exp_start: 1'b1, exp_rsp: 1'b1, textout: {24{8'hA5}}};
    vecs[2] = '{op: 4'h0, data: {6{32'hdeadbeef}}, lat: 2, exp_start: 1'b0, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[3] = '{op: 4'hA, data: {6{32'h11223344}}, lat: 2, exp_start: 1'b1, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[4] = '{op: 4'h5, data: {6{32'hcafef00d}}, lat: 1, exp_start: 1'b1, exp_rsp: 1'b1, textout: {6{32'h5a5a0ff0}}};
    vecs[5] = '{op: 4'hE, data: {6{32'h00000001}}, lat: 4, exp_start: 1'b1, exp_rsp: 1'b1, textout: {6{32'h87654321}}};
    vecs[6] = '{op: 4'h3, data: {6{32'hfeedface}}, lat: 4, exp_start: 1'b1, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[7] = '{op: 4'h8, data: {6{32'h13579bdf}}, lat: 2, exp_start: 1'b0, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[8] = '{op: 4'h7, data: {6{32'h2468ace0}}, lat: 1, exp_start: 1'b1, exp_rsp: 1'b0, textout: {TEXT_W{1'b0}}};
    vecs[9] = '{op: 4'hC, data: {6{32'h0f1e2d3c}}, lat: 2, exp_start: 1'b1, exp_rsp: 1'b1, textout: {6{32'hffff0000}}};

    // Reset state.
    reset = 1'b0;
    cyc();
    cyc();
    chk_reset_outputs("init");
    reset = 1'b1;
    cyc();

    // Single commands into an empty, idle sequencer.
    for (int i = 0; i < NV; i++) begin
      core_lat  = vecs[i].lat;
      use_fixed = 1'b1;
      fixed_out = vecs[i].textout;
      rsp_ready = 1'b0;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      cmd_valid = 1'b1;
      cyc();
      chk($sformatf("v%0d_accept", i), 256'(s_acc), 256'(1));
      cmd_valid = 1'b0;
      nstart = 0; start_k = 0; rsp_k = 0; stable = 1'b1; busy_at = 1'b1;
      st_op = '0; st_txt = '0; r_op = '0; r_data = '0;
      for (int k = 1; k <= vecs[i].lat + 6; k++) begin
        cyc();
        if (s_start) begin
          nstart++;
          if (start_k == 0) begin
            start_k = k;
            st_op   = s_opmode;
            st_txt  = s_textin;
          end
        end
        if (s_rsp_valid) begin
          if (rsp_k == 0) begin
            rsp_k  = k;
            r_op   = s_rsp_op;
            r_data = s_rsp_data;
          end else if (s_rsp_op !== r_op || s_rsp_data !== r_data) begin
            stable = 1'b0;
          end
        end
        if (k == vecs[i].lat + 3) busy_at = s_busy;
      end
      chk($sformatf("v%0d_start_count", i), 256'(nstart), 256'(vecs[i].exp_start));
      if (vecs[i].exp_start) begin
        chk($sformatf("v%0d_start_cycle", i), 256'(start_k), 256'(2));
        chk($sformatf("v%0d_opmode", i), 256'(st_op), 256'(vecs[i].op));
        chk($sformatf("v%0d_textin", i), 256'(st_txt), 256'(vecs[i].data));
      end
      chk($sformatf("v%0d_rsp_seen", i), 256'(rsp_k != 0), 256'(vecs[i].exp_rsp));
      if (vecs[i].exp_rsp) begin
        chk($sformatf("v%0d_rsp_cycle", i), 256'(rsp_k), 256'(vecs[i].lat + 3));
        chk($sformatf("v%0d_rsp_op", i), 256'(r_op), 256'(vecs[i].op));
        chk($sformatf("v%0d_rsp_data", i), 256'(r_data), 256'(vecs[i].textout));
        chk($sformatf("v%0d_rsp_stable", i), 256'(stable), 256'(1));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        cyc();
      end else if (vecs[i].exp_start) begin
        chk($sformatf("v%0d_busy_after_finish", i), 256'(busy_at), 256'(0));
      end
      chk($sformatf("v%0d_idle", i), 256'(busy), 256'(0));
      $display("vec %0d op=%h starts=%0d start_cycle=%0d rsp_cycle=%0d", i, vecs[i].op, nstart, start_k, rsp_k);
    end

    // FIFO full with the core stalled on a ratchet.
    use_fixed  = 1'b0;
    rand_lat   = 1'b1;
    core_stall = 1'b1;
    sb_en      = 1'b1;
    rsp_ready  = 1'b1;
    begin
      logic [3:0] fill_ops [5];
      fill_ops = '{4'h7, 4'h1, 4'h2, 4'h3, 4'h4};
      for (int i = 0; i < 5; i++) begin
        cmd_op    = fill_ops[i];
        cmd_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        cmd_valid = 1'b1;
        cyc();
        chk($sformatf("fill_accept%0d", i), 256'(s_acc), 256'(1));
      end
    end
    cmd_op = 4'h6;
    nacc   = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      nacc += int'(s_acc);
      chk("fill_count", 256'(s_count), 256'(DEPTH));
      chk("fill_ready_low", 256'(s_ready), 256'(0));
    end
    chk("fill_fifth_rejected", 256'(nacc), 256'(0));
    cmd_valid  = 1'b0;
    core_stall = 1'b0;
    drain("fill", 300);
    chk("fill_issue_queue_empty", 256'(exp_iss.size()), 256'(0));
    chk("fill_rsp_queue_empty", 256'(exp_rsp.size()), 256'(0));
    $display("fill sequence done");

    // Reset while waiting on the core with two entries queued.
    rand_lat   = 1'b0;
    core_lat   = 2;
    core_stall = 1'b1;
    begin
      logic [3:0] rst_ops [3];
      rst_ops = '{4'h7, 4'h4, 4'h5};
      for (int i = 0; i < 3; i++) begin
        cmd_op    = rst_ops[i];
        cmd_data  = {6{32'(i + 32'h100)}};
        cmd_valid = 1'b1;
        cyc();
      end
    end
    cmd_valid = 1'b0;
    cyc();
    cyc();
    chk("rstw_pre_count", 256'(s_count), 256'(2));
    chk("rstw_pre_busy", 256'(s_busy), 256'(1));
    reset = 1'b0;
    cyc();
    chk_reset_outputs("rstw");
    reset      = 1'b1;
    core_stall = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      nrsp += int'(s_rsp_valid);
    end
    chk("rstw_no_response", 256'(nrsp), 256'(0));
    chk("rstw_idle", 256'(busy), 256'(0));
    $display("reset-in-wait sequence done");

    // Core never finishes.
    sb_en      = 1'b0;
    core_stall = 1'b1;
    core_lat   = 1;
    cmd_op     = 4'h1;
    cmd_data   = {6{32'h0badf00d}};
    cmd_valid  = 1'b1;
    cyc();
    chk("tmo_accept", 256'(s_acc), 256'(1));
    cmd_valid = 1'b0;
    nstart = 0;
    err18  = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      cyc();
      nstart += int'(s_start);
      if (k == 18) err18 = s_err;
    end
    chk("tmo_start_count", 256'(nstart), 256'(1));
`ifdef XOODYAK_SEQ_TIMEOUT_EN
    chk("tmo_err_before_limit", 256'(err18), 256'(0));
    chk("tmo_err_set", 256'(s_err), 256'(1));
    chk("tmo_ready_low", 256'(s_ready), 256'(0));
    cmd_op    = 4'h2;
    cmd_valid = 1'b1;
    nstart = 0;
    nacc   = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      nstart += int'(s_start);
      nacc   += int'(s_acc);
    end
    chk("err_no_start", 256'(nstart), 256'(0));
    chk("err_no_accept", 256'(nacc), 256'(0));
    chk("err_count_frozen", 256'(s_count), 256'(0));
    chk("err_sticky", 256'(s_err), 256'(1));
`else
    chk("notmo_err_before", 256'(err18), 256'(0));
    chk("notmo_err", 256'(s_err), 256'(0));
    chk("notmo_busy", 256'(s_busy), 256'(1));
    chk("notmo_ready", 256'(s_ready), 256'(1));
    for (int i = 0; i < 30; i++) cyc();
    chk("notmo_err_late", 256'(s_err), 256'(0));
    chk("notmo_still_waiting", 256'(s_busy), 256'(1));
`endif
    cmd_valid = 1'b0;
    reset = 1'b0;
    cyc();
    chk_reset_outputs("tmo_rst");
    reset      = 1'b1;
    core_stall = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("tmo_after_reset_idle", 256'(busy), 256'(0));
    $display("timeout sequence done");

    // Random command stream against the reference model.
    sb_en      = 1'b1;
    use_fixed  = 1'b0;
    rand_lat   = 1'b1;
    core_stall = 1'b0;
    for (int c = 0; c < 800; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rsp_ready = ($urandom_range(0, 1) != 0);
      cyc();
    end
    drain("rand", 400);
    chk("rand_issue_queue_empty", 256'(exp_iss.size()), 256'(0));
    chk("rand_rsp_queue_empty", 256'(exp_rsp.size()), 256'(0));
    chk("rand_err_clear", 256'(err), 256'(0));
    $display("random stream done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
